// File: rtl/seq_penc_pkg.sv
// Package for seq_priority_encoder.
// Holds the FSM state type and two helpers:
//   idx_w      - index width for an N-bit request vector (at least 1 bit)
//   pop_is_one - true when exactly one bit of a vector is set
// Vectors up to MAX_N bits are supported by pop_is_one; callers zero-extend.
package seq_penc_pkg;

  localparam int MAX_N = 64;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  function automatic logic pop_is_one(input logic [MAX_N-1:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

endpackage

// File: rtl/seq_priority_encoder_prio_find.sv
// prio_find: combinational priority search over an N-bit vector.
// Ports:
//   vec_i   [N-1:0]  vector to search
//   idx_o   [W-1:0]  index of the winning set bit (0 when none set)
//   found_o          at least one bit of vec_i is set
// MSB_FIRST=1 selects the highest set bit, otherwise the lowest.
module prio_find
  import seq_penc_pkg::*;
#(
  parameter int N         = 10,
  parameter bit MSB_FIRST = 1'b1,
  parameter int W         = idx_w(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // The loop direction makes the last match seen the priority winner.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (vec_i[i]) begin
          idx_o   = W'(i);
          found_o = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec_i[i]) begin
          idx_o   = W'(i);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_priority_encoder.sv
// seq_priority_encoder: accepts an N-bit request vector over a valid/ready
// handshake and emits the index of every set bit, one beat per output
// handshake, in priority order. An all-zero vector yields one beat with
// out_none=1.
// Ports:
//   clk, rst                 clock, async active-high reset
//   enable                   low blocks acceptance and freezes emission
//   in_valid/in_ready/in_vec input handshake and request vector
//   out_valid/out_ready      output handshake
//   out_idx, out_last        current index, final beat of the vector
//   out_none                 accepted vector was all-zero
//
// state | meaning
// IDLE  | waiting for a vector; in_ready follows enable
// EMIT  | shadow vector holds the bits still to be emitted
module seq_priority_encoder
  import seq_penc_pkg::*;
#(
  parameter int N         = 10,
  parameter int W         = idx_w(N),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none
);

  state_e         state_q, state_d;
  logic [N-1:0]   vec_q, vec_d;
  logic           valid_q, valid_d;

  logic [W-1:0]   win_idx;
  logic           win_found;
  logic           last_now;
  logic           fire;

  prio_find #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST),
    .W         (W)
  ) u_find (
    .vec_i   (vec_q),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  // An empty shadow vector is the all-zero beat, which is also the last one.
  assign last_now = pop_is_one(MAX_N'(vec_q)) | ~win_found;

  // enable gates the handshake so a beat presented while disabled is not lost.
  assign fire = valid_q & out_ready & enable;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    valid_d  = valid_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = enable & ~rst;
        valid_d  = 1'b0;
        if (in_valid && enable) begin
          vec_d   = in_vec;
          state_d = EMIT;
          valid_d = 1'b1;
        end
      end
      EMIT: begin
        if (fire) begin
          vec_d = vec_q & ~(N'(1) << win_idx);
          if (last_now) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            valid_d = 1'b1;
          end
        end else begin
          valid_d = enable;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
    end
  end

  // Outputs depend only on registered state; forced to 0 when no beat is shown.
  assign out_valid = valid_q;
  assign out_idx   = valid_q ? win_idx : '0;
  assign out_last  = valid_q & last_now;
  assign out_none  = valid_q & ~win_found;

endmodule

// File: tb/tb_seq_priority_encoder.sv
module tb_seq_priority_encoder;

  typedef struct packed {
    logic [3:0] idx;
    logic       last;
    logic       none;
  } beat_t;

  logic       clk;
  logic       rst;
  logic       enable, in_valid, in_ready, out_valid, out_ready, out_last, out_none;
  logic [9:0] in_vec;
  logic [3:0] out_idx;

  logic       b_enable, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_out_none;
  logic [9:0] b_in_vec;
  logic [3:0] b_out_idx;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t qa[$];
  beat_t qb[$];

  seq_priority_encoder #(.N(10), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .out_none(out_none)
  );

  seq_priority_encoder #(.N(10), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .enable(b_enable), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_vec(b_in_vec), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
    .out_last(b_out_last), .out_none(b_out_none)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: list set bits in priority order; zero vector gives one none-beat.
  task automatic push_exp(input logic [9:0] v, input bit msb, input bit to_b);
    beat_t b;
    int    cnt;
    int    seen;
    cnt  = $countones(v);
    seen = 0;
    if (cnt == 0) begin
      b.idx = 4'd0; b.last = 1'b1; b.none = 1'b1;
      if (to_b) qb.push_back(b); else qa.push_back(b);
    end else begin
      for (int k = 0; k < 10; k++) begin
        int i;
        i = msb ? 9 - k : k;
        if (v[i]) begin
          seen++;
          b.idx  = 4'(i);
          b.last = (seen == cnt);
          b.none = 1'b0;
          if (to_b) qb.push_back(b); else qa.push_back(b);
        end
      end
    end
  endtask

  // Scoreboard: push on input acceptance, pop and compare on output beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) push_exp(in_vec, 1'b1, 1'b0);
      if (b_in_valid && b_in_ready) push_exp(b_in_vec, 1'b0, 1'b1);
      if (out_valid && out_ready && enable) begin
        if (qa.size() == 0) check("a_unexpected_beat", qa.size(), 1);
        else begin
          beat_t e;
          e = qa.pop_front();
          check("a_idx", out_idx, e.idx);
          check("a_last", out_last, e.last);
          check("a_none", out_none, e.none);
        end
      end
      if (b_out_valid && b_out_ready && b_enable) begin
        if (qb.size() == 0) check("b_unexpected_beat", qb.size(), 1);
        else begin
          beat_t e;
          e = qb.pop_front();
          check("b_idx", b_out_idx, e.idx);
          check("b_last", b_out_last, e.last);
          check("b_none", b_out_none, e.none);
        end
      end
    end
  end

  task automatic send_a(input logic [9:0] v);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_vec   = v;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("a_accept_timeout", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain_a();
    for (int c = 0; c < 60; c++) begin
      if (qa.size() == 0) break;
      @(negedge clk);
    end
    check("a_drain_timeout", qa.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
    b_enable = 1'b1; b_in_valid = 1'b0; b_in_vec = '0; b_out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_none", out_none, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // single top bit, latency 1
    send_a(10'b1000000000);
    @(negedge clk);
    check("t1_latency_valid", out_valid, 1);
    drain_a();
    @(negedge clk);
    check("t1_in_ready_after", in_ready, 1);
    @(posedge clk); #1;

    // back-to-back beats
    send_a(10'b0101001010);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t2_valid_b2b", out_valid, 1);
      check("t2_in_ready_low", in_ready, 0);
    end
    drain_a();

    // all-zero vector
    send_a(10'b0);
    @(negedge clk);
    check("t3_none", out_none, 1);
    drain_a();

    // backpressure holds outputs
    out_ready = 1'b0;
    send_a(10'b0001000001);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_idx", out_idx, 6);
      check("t4_hold_last", out_last, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain_a();

    // disabled: nothing accepted
    enable = 1'b0; in_valid = 1'b1; in_vec = 10'b1111111111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5_dis_in_ready", in_ready, 0);
      check("t5_dis_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; enable = 1'b1;

    // enable dropped after first beat
    send_a(10'b0000010001);
    @(negedge clk);
    check("t5_first_idx", out_idx, 4);
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_frozen_valid", out_valid, 0);
    @(negedge clk);
    check("t5_frozen_valid2", out_valid, 0);
    check("t5_pending", qa.size(), 1);
    @(posedge clk); #1;
    enable = 1'b1;
    drain_a();

    // reset mid-emit
    out_ready = 1'b0;
    send_a(10'b0101001010);
    @(negedge clk);
    check("t6_pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid_async", out_valid, 0);
    check("t6_rst_in_ready", in_ready, 0);
    qa.delete();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("t6_post_in_ready", in_ready, 1);
    check("t6_post_valid", out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // LSB-first instance
    begin
      bit ok;
      ok = 1'b0;
      b_in_valid = 1'b1; b_in_vec = 10'b0001000010;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (b_in_ready) begin ok = 1'b1; break; end
      end
      check("b_accept_timeout", ok, 1);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      @(negedge clk);
      check("b_first_idx", b_out_idx, 1);
      for (int c = 0; c < 60; c++) begin
        if (qb.size() == 0) break;
        @(negedge clk);
      end
      check("b_drain_timeout", qb.size(), 0);
    end

    repeat (3) @(posedge clk);
    check("a_queue_empty_end", qa.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
- Parametrised, sequential successor to the team's 10-to-4 BCD/priority encoder.
- Accepts an N-bit request vector through a valid/ready handshake.
- Emits the index of every set bit, one per output handshake, in priority order, and flags the last index.
- Sits between request-collection logic and downstream schedulers that need each active line serviced individually.

Parameters:
- N, 10, width of the input request vector (N >= 2).
- W, $clog2(N), width of the output index. Derived; do not override.
- MSB_FIRST, 1, priority order. 1 emits the highest set index first; 0 emits the lowest first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  block enable. Low blocks acceptance and freezes emission.
- in_valid  input  1  in_vec is valid this cycle.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  N  request vector.
- out_valid  output  1  out_idx, out_last and out_none are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_idx  output  W  index of the current set bit.
- out_last  output  1  current beat is the final beat for the accepted vector.
- out_none  output  1  accepted vector was all-zero; out_idx is 0 on this beat.

Behaviour:
- Reset (async assert, sync release): state=IDLE, shadow vector=0. out_valid, out_idx, out_last, out_none all 0. in_ready=0 while rst is high.
- States: IDLE and EMIT.
- IDLE:
  - in_ready = enable.
  - On in_valid & in_ready at edge k: latch in_vec into the shadow register and go to EMIT.
  - out_valid rises in cycle k+1 (latency 1).
  - All outputs are registered.
- EMIT:
  - in_ready=0; no new vector is accepted while emitting.
  - out_idx = the priority-winning set bit of the shadow vector.
  - out_last=1 when exactly one bit remains set.
  - On out_valid & out_ready: clear the emitted bit in the shadow vector.
  - If out_last was 1, return to IDLE. Otherwise, present the next index in the next cycle.
  - Back-to-back beats run at one per cycle while out_ready=1.
- All-zero vector: exactly one beat with out_none=1, out_last=1, out_idx=0, then IDLE.
- Backpressure: while out_valid & !out_ready, out_idx, out_last and out_none are held stable.
- enable low in EMIT:
  - out_valid drops to 0 in the next cycle.
  - State and shadow vector are held.
  - Emission resumes with the same pending index once enable returns.
- After returning to IDLE, in_ready=1 in the following cycle (given enable=1). There is no same-cycle turnaround.
- rst asserted mid-EMIT: outputs clear immediately and the pending vector is discarded.
- out_idx always lies in 0..N-1. Indices >= N are unreachable.

Decomposition:
- Package seq_penc_pkg:
  - state enum {IDLE, EMIT}.
  - index-width helper function.
  - popcount-is-one helper used for out_last.
- Sub-module prio_find #(N, MSB_FIRST): combinational. Takes an N-bit vector and returns idx[W-1:0] and found. Instantiated once on the shadow vector.

Test Plan (N=10, MSB_FIRST=1 unless noted):
1. enable=1, in_vec=10'b1000000000, out_ready=1 -> one beat one cycle after accept: out_idx=9, out_last=1, out_none=0. Then in_ready=1.
2. in_vec=10'b0101001010, out_ready=1 -> out_idx 8,6,3,1 on consecutive cycles; out_last only on 1; in_ready=0 throughout.
3. in_vec=0 -> single beat: out_none=1, out_last=1, out_idx=0.
4. in_vec=10'b0001000001, out_ready low for 3 cycles -> out_idx=6 held stable for 3 cycles. After release: 6 then 0 (last).
5. enable=0 with in_valid=1 -> in_ready=0, no beats. enable dropped after first beat of 10'b0000010001 -> out_valid=0, and out_idx=0 is emitted when enable returns.
6. rst pulsed mid-EMIT -> out_valid=0 asynchronously and in_ready=enable after release. Separately, MSB_FIRST=0 with 10'b0001000010 -> 1 then 6 (last).
